pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Synthesizable, table-driven timed stimulus player.
- Drives a WIDTH-bit vector, e.g. the 19-bit switches_and_buttons bus of top, from a DEPTH-entry program of (pattern, duration) steps.
- Replaces hand-written timed initial blocks with a reusable block usable on-board or in simulation.
- Adds run/stop control, loop mode and status that a fixed stimulus sequence lacks.

Parameters:
- WIDTH, 19: width of each pattern and of pattern_out.
- DEPTH, 16: number of program entries (power of two, ≥2).
- CNT_W, 24: width of per-step duration field, in clk cycles.
- IDLE_PATTERN, 0: pattern_out value in reset and IDLE.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write program entry this cycle.
- wr_addr  in  log2(DEPTH)  entry index to write.
- wr_pattern  in  WIDTH  pattern for entry.
- wr_duration  in  CNT_W  hold time in cycles; 0 = hold until stop.
- num_steps  in  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- loop_en  in  1  wrap to entry 0 after last step.
- start  in  1  begin from entry 0.
- stop  in  1  abort, return to IDLE.
- pattern_out  out  WIDTH  current stimulus vector (registered).
- step_idx  out  log2(DEPTH)  index of entry being played.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst=0, async): state=IDLE, pattern_out=IDLE_PATTERN, step_idx=0, busy=0, done=0, counter=0. Program memory is not cleared.
- Memory: DEPTH x (WIDTH+CNT_W) registers, synchronous write on wr_en. Writes are legal in any state. A write to an entry takes effect when that entry is next loaded; the currently playing step is never altered.
- States:
  - IDLE: on start && !stop && num_steps≠0, go to RUN. Load entry 0: pattern_out, step_idx=0, counter=duration. All take effect on the cycle after start (latency 1).
  - RUN: a step with duration D≥1 holds pattern_out for exactly D cycles, then the next entry appears on cycle D+1. Counter decrements each cycle; at counter==1 the next entry loads.
  - RUN, duration 0: step holds indefinitely; only stop or start leaves it.
  - RUN, last step (step_idx==num_steps-1) expiry with loop_en=1: load entry 0 seamlessly, no gap cycle.
  - RUN, last step expiry with loop_en=0: go to DONE, pattern_out holds last pattern, done=1 for that single cycle, busy=0.
  - DONE: outputs hold. start restarts as in IDLE. stop goes to IDLE with pattern_out=IDLE_PATTERN.
- stop in any state: next cycle IDLE, pattern_out=IDLE_PATTERN, step_idx=0, done=0.
- start && stop together: stop wins.
- start while in RUN: restart from entry 0 next cycle, no done pulse.
- num_steps==0: start ignored.
- num_steps>DEPTH: clamp to DEPTH.
- num_steps and loop_en are sampled at every step boundary, so changes mid-run apply at the next boundary.
- Reset asserted mid-run: immediate return to reset values.
- Counter is unsigned CNT_W bits with no wrap. Maximum step length is 2^CNT_W-1 cycles.

Optional Feature:
- Macro: PATSEQ_STEP_PULSE_EN.
- Defined: adds output step_pulse (1 bit), high for exactly one cycle whenever a new entry is loaded into pattern_out. This covers the first load after start, every step advance and every loop wrap. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Program 3 entries {19'h00002/5, 19'h00006/10, 19'h00001/4}, num_steps=3, loop_en=0, pulse start at cycle 0 -> pattern_out 00002 cycles 1–5, 00006 cycles 6–15, 00001 cycles 16–19. done=1 at cycle 20 only, pattern_out stays 00001, busy low from cycle 20.
- Same program, loop_en=1 -> after 00001 for 4 cycles, 00002 reappears on cycle 20 with no gap. step_idx sequence 0,1,2,0; done never pulses.
- Entry 1 duration 0 -> pattern_out stays 00006 for 1000 cycles. Assert stop -> next cycle pattern_out=0, busy=0.
- Assert stop and start on the same cycle during RUN -> IDLE, pattern_out=IDLE_PATTERN. Start with num_steps=0 -> no state change.
- During step 0, write entry 1 with pattern 7FFFF -> step 0 unaffected, 7FFFF plays as step 1. Drop rst mid-step 1 -> pattern_out=0, busy=0 asynchronously.
- With PATSEQ_STEP_PULSE_EN defined, run test 1 -> step_pulse high exactly on cycles 1, 6, 16.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Table-driven timed stimulus player: steps through (pattern, duration) entries.
// Optional macro PATSEQ_STEP_PULSE_EN adds a step_pulse output on every entry load.
module pattern_sequencer #(
  parameter int                WIDTH        = 19,
  parameter int                DEPTH        = 16,
  parameter int                CNT_W        = 24,
  parameter logic [WIDTH-1:0]  IDLE_PATTERN = '0,
  localparam int               AW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_pattern,
  input  logic [CNT_W-1:0] wr_duration,
  input  logic [AW:0]      num_steps,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] pattern_out,
  output logic [AW-1:0]    step_idx,
  output logic             busy,
  output logic             done
`ifdef PATSEQ_STEP_PULSE_EN
  ,
  output logic             step_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0] NS_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_pat [DEPTH];
  logic [CNT_W-1:0] mem_dur [DEPTH];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [AW-1:0]    step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [AW:0]      ns_eff;
  logic             last;
  logic             load;
  logic [AW-1:0]    load_idx;

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pat[wr_addr] <= wr_pattern;
      mem_dur[wr_addr] <= wr_duration;
    end
  end

  always_comb begin
    ns_eff = (num_steps > NS_MAX) ? NS_MAX : num_steps;
    last   = ({1'b0, step_q} + (AW+1)'(1)) >= ns_eff;
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;
    if (stop) begin
      state_d = IDLE;
      pat_d   = IDLE_PATTERN;
      step_d  = '0;
      cnt_d   = '0;
    end else if (start && ns_eff != '0) begin
      state_d  = RUN;
      load     = 1'b1;
      load_idx = '0;
    end else if (state_q == RUN && cnt_q == CNT_W'(1)) begin
      if (last && !loop_en) begin
        state_d = DONE;
        done_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        load     = 1'b1;
        load_idx = last ? '0 : step_q + AW'(1);
      end
    end else if (state_q == RUN && cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // A zero duration never reaches 1, so the step holds until start/stop.
    if (load) begin
      pat_d  = mem_pat[load_idx];
      step_d = load_idx;
      cnt_d  = mem_dur[load_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= IDLE_PATTERN;
      step_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef PATSEQ_STEP_PULSE_EN
  logic pulse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse_q <= 1'b0;
    else      pulse_q <= load;
  end

  assign step_pulse = pulse_q;
`endif

  assign pattern_out = pat_q;
  assign step_idx    = step_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed scoreboard bench for pattern_sequencer.
// Expectations are queued per cycle and compared #1 after each rising edge.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [18:0] wr_pattern;
  logic [23:0] wr_duration;
  logic [4:0]  num_steps;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [18:0] pattern_out;
  logic [3:0]  step_idx;
  logic        busy;
  logic        done;
`ifdef PATSEQ_STEP_PULSE_EN
  logic        step_pulse;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [18:0] pat;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic        pulse;
  } exp_t;

  exp_t sb[$];

  pattern_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_pattern  (wr_pattern),
    .wr_duration (wr_duration),
    .num_steps   (num_steps),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .pattern_out (pattern_out),
    .step_idx    (step_idx),
    .busy        (busy),
    .done        (done)
`ifdef PATSEQ_STEP_PULSE_EN
    ,
    .step_pulse  (step_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [18:0] p, input logic [3:0] i,
                      input logic b, input logic d, input logic pl);
    exp_t e;
    e.pat = p; e.idx = i; e.busy = b; e.done = d; e.pulse = pl;
    sb.push_back(e);
  endtask

  task automatic push_run(input int n, input logic [18:0] p,
                          input logic [3:0] i);
    for (int k = 0; k < n; k++) push(p, i, 1'b1, 1'b0, k == 0);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("pattern_out", 32'(pattern_out), 32'(e.pat));
      chk("step_idx", 32'(step_idx), 32'(e.idx));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
`ifdef PATSEQ_STEP_PULSE_EN
      chk("step_pulse", 32'(step_pulse), 32'(e.pulse));
`endif
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [18:0] p,
                    input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_pattern = p; wr_duration = d;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_pattern = '0;
    wr_duration = '0; num_steps = '0; loop_en = 1'b0;
    start = 1'b0; stop = 1'b0;
    #1;
    chk("rst_pattern", 32'(pattern_out), 32'h0);
    chk("rst_step", 32'(step_idx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    #1 rst = 1'b1;
    cyc();

    wr(4'd0, 19'h00002, 24'd5);
    wr(4'd1, 19'h00006, 24'd10);
    wr(4'd2, 19'h00001, 24'd4);
    num_steps = 5'd3;

    // Single pass ending in a done pulse
    push_run(5, 19'h00002, 4'd0);
    push_run(10, 19'h00006, 4'd1);
    push_run(4, 19'h00001, 4'd2);
    push(19'h00001, 4'd2, 1'b0, 1'b1, 1'b0);
    push(19'h00001, 4'd2, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 20; k++) cyc();

    // Restart from DONE in loop mode, seamless wrap
    loop_en = 1'b1;
    push_run(5, 19'h00002, 4'd0);
    push_run(10, 19'h00006, 4'd1);
    push_run(4, 19'h00001, 4'd2);
    push_run(5, 19'h00002, 4'd0);
    push_run(1, 19'h00006, 4'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 24; k++) cyc();

    push(19'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Zero duration holds until stop
    loop_en = 1'b0;
    wr(4'd1, 19'h00006, 24'd0);
    push_run(5, 19'h00002, 4'd0);
    push_run(1000, 19'h00006, 4'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 1004; k++) cyc();
    push(19'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Stop beats start; num_steps==0 ignores start
    wr(4'd1, 19'h00006, 24'd10);
    push_run(2, 19'h00002, 4'd0);
    push(19'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(19'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(19'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; stop = 1'b1;
    cyc();
    stop = 1'b0;
    num_steps = 5'd0;
    cyc();
    start = 1'b0;
    cyc();
    num_steps = 5'd3;

    // Mid-step write to next entry, then async reset
    push_run(5, 19'h00002, 4'd0);
    push_run(3, 19'h7FFFF, 4'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wr(4'd1, 19'h7FFFF, 24'd10);
    for (int k = 0; k < 6; k++) cyc();
    #3 rst = 1'b0;
    #1;
    chk("arst_pattern", 32'(pattern_out), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_step", 32'(step_idx), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
